// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external single-clock dual-port RAM.
// Port A writes at the tail and port B continuously reads the head; rd_data is the RAM's registered output.
module mor1kx_dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH     = PW'(2 ** ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] count_nxt;
  logic          rd_valid_q;
  logic          almost_full_q;
  logic          push;
  logic          pop;

  // Pointers carry one extra bit so full and empty differ.
  assign count      = wr_ptr - rd_ptr;
  assign wr_ready   = (count != DEPTH);
  assign push       = wr_valid & wr_ready & ~flush;
  assign pop        = rd_valid_q & rd_ready & ~flush;
  assign wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, pop};
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  assign ram_addr_a  = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_we_a    = push;
  assign ram_din_a   = wr_data;
  assign ram_addr_b  = rd_ptr_nxt[ADDR_WIDTH-1:0];
  assign ram_we_b    = 1'b0;
  assign ram_din_b   = '0;
  assign rd_data     = ram_dout_b;
  assign rd_valid    = rd_valid_q;
  assign almost_full = almost_full_q;

  // rd_valid uses the registered wr_ptr: a push becomes readable only once
  // the RAM has had a cycle to register the written slot on port B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_valid_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_valid_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      rd_valid_q    <= ((wr_ptr - rd_ptr_nxt) != '0);
      almost_full_q <= (count_nxt >= AFULL_THR);
    end
  end

endmodule

// File: tb/tb_mor1kx_dpram_fifo_ctrl.sv
// Scoreboard bench for mor1kx_dpram_fifo_ctrl with a behavioural dual-port RAM attached.
module tb_mor1kx_dpram_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [AW:0]   count;
  logic          almost_full;
  logic [AW-1:0] ram_addr_a;
  logic          ram_we_a;
  logic [DW-1:0] ram_din_a;
  logic [AW-1:0] ram_addr_b;
  logic          ram_we_b;
  logic [DW-1:0] ram_din_b;
  logic [DW-1:0] ram_dout_b;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] sb [$];
  logic          model_rv;
  logic          model_af;
  int            vectors;
  int            miscompares;

  mor1kx_dpram_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .count      (count),
    .almost_full(almost_full),
    .ram_addr_a (ram_addr_a),
    .ram_we_a   (ram_we_a),
    .ram_din_a  (ram_din_a),
    .ram_addr_b (ram_addr_b),
    .ram_we_b   (ram_we_b),
    .ram_din_b  (ram_din_b),
    .ram_dout_b (ram_dout_b)
  );

  always #5 clk = ~clk;

  // Registered-output RAM; a same-address read returns the old contents.
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive, check mid-cycle against the model, then advance the model.
  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    logic          exp_push;
    logic          exp_pop;
    logic [DW-1:0] exp_data;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(negedge clk);
    exp_push = wv && !fl && (sb.size() != DEPTH);
    exp_pop  = model_rv && rr && !fl;
    checkOutput("wr_ready", 32'(wr_ready), 32'(sb.size() != DEPTH));
    checkOutput("count", 32'(count), 32'(sb.size()));
    checkOutput("rd_valid", 32'(rd_valid), 32'(model_rv));
    checkOutput("almost_full", 32'(almost_full), 32'(model_af));
    checkOutput("ram_we_a", 32'(ram_we_a), 32'(exp_push));
    if (exp_pop && sb.size() > 0) begin
      exp_data = sb.pop_front();
      checkOutput("rd_data", rd_data, exp_data);
    end
    if (exp_push) sb.push_back(wd);
    if (fl) begin
      sb.delete();
      model_rv = 1'b0;
    end else begin
      model_rv = ((sb.size() - int'(exp_push)) != 0);
    end
    model_af = (sb.size() >= AFULL);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && sb.size() > 0; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rv"}, 32'(rd_valid), 32'd0);
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    checkOutput({tag, "_afull"}, 32'(almost_full), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_rv    = 1'b0;
    model_af    = 1'b0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    rd_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    checkOutput("ram_we_b", 32'(ram_we_b), 32'd0);
    rst_n = 1'b1;

    // Single push: invisible one cycle later, head valid two cycles later.
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    checkOutput("t1_rv_c1", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t1_rv_c2", 32'(rd_valid), 32'd1);
    checkOutput("t1_data_c2", rd_data, 32'hA5A5_0001);
    drain();

    // Fill to full, offer an extra word, then empty it.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h0000_0100 + 32'(i), 1'b0, 1'b0);
    checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("full_count", 32'(count), 32'd16);
    applyStimulus(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    drain();

    // Streaming across several pointer wraps.
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
    drain();

    // Full, pop once, and push into the freed slot on the next cycle.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("refill_wr_ready", 32'(wr_ready), 32'd1);
    applyStimulus(1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
    drain();

    // Flush with a simultaneous push and pop request.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_5555, 1'b1, 1'b1);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_rv", 32'(rd_valid), 32'd0);
    applyStimulus(1'b1, 32'h0000_0077, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("post_flush_rv", 32'(rd_valid), 32'd1);
    checkOutput("post_flush_data", rd_data, 32'h0000_0077);
    drain();

    // almost_full threshold crossing in both directions.
    for (int i = 0; i < AFULL - 1; i++) applyStimulus(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
    checkOutput("af_11", 32'(almost_full), 32'd0);
    applyStimulus(1'b1, 32'h4000_00FF, 1'b0, 1'b0);
    checkOutput("af_12", 32'(almost_full), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("af_pop", 32'(almost_full), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h5000_0000 + 32'(i), 1'b0, 1'b0);

    // Asynchronous reset away from any clock edge.
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    sb.delete();
    model_rv = 1'b0;
    model_af = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h6000_0000 + 32'(i), 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
